// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC: PCM handshake, STGS-stage CIC interpolator (x BOSR), 1-bit PDM modulator.
// Define SIGMA_DELTA_DAC_SECOND_ORDER_EN to swap the first-order modulator for a second-order loop.
module sigma_delta_dac #(
   parameter int BOSR  = 256,
   parameter int STGS  = 2,
   parameter int WDTH  = 16,
   parameter int IWDTH = WDTH + STGS * $clog2(BOSR)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [WDTH-1:0] din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic                   pdm_out,
   output logic                   underrun
);

   localparam int LOGR  = $clog2(BOSR);
   localparam int SHIFT = (STGS - 1) * LOGR;

   logic [LOGR-1:0]         cnt_q;
   logic                    tick;
   logic                    xfer;
   logic signed [WDTH-1:0]  hold_q;
   logic                    hold_full_q;
   logic                    started_q;
   logic signed [WDTH-1:0]  cur_q;
   logic                    underrun_q;
   logic                    comb_en_q;
   logic                    inj_en_q;

   logic signed [IWDTH-1:0] comb_z_q   [STGS];
   logic signed [IWDTH-1:0] comb_z_d   [STGS];
   logic signed [IWDTH-1:0] comb_out_q;
   logic signed [IWDTH-1:0] comb_out_d;
   logic signed [IWDTH-1:0] int_q      [STGS];
   logic signed [IWDTH-1:0] inj;
   logic signed [WDTH-1:0]  y_q;
   logic                    pdm_q;
   logic                    pdm_d;

   assign tick      = (cnt_q == LOGR'(BOSR - 1));
   assign din_ready = ~hold_full_q;
   assign xfer      = din_valid & ~hold_full_q;
   assign underrun  = underrun_q;
   assign pdm_out   = pdm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         started_q   <= 1'b0;
         cur_q       <= '0;
         underrun_q  <= 1'b0;
         comb_en_q   <= 1'b0;
         inj_en_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_q + LOGR'(1);
         comb_en_q  <= tick;
         inj_en_q   <= comb_en_q;
         underrun_q <= tick & ~hold_full_q & started_q;
         if (xfer) begin
            hold_q    <= din;
            started_q <= 1'b1;
         end
         // xfer needs an empty hold, so it never collides with the consume branch
         if (tick && hold_full_q) begin
            cur_q       <= hold_q;
            hold_full_q <= 1'b0;
         end else if (xfer) begin
            hold_full_q <= 1'b1;
         end
      end
   end

   always_comb begin
      comb_out_d = {{(IWDTH - WDTH){cur_q[WDTH-1]}}, cur_q};
      for (int unsigned k = 0; k < STGS; k++) begin
         comb_z_d[k] = comb_out_d;
         comb_out_d  = comb_out_d - comb_z_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STGS; k++) comb_z_q[k] <= '0;
         comb_out_q <= '0;
      end else if (comb_en_q) begin
         for (int unsigned k = 0; k < STGS; k++) comb_z_q[k] <= comb_z_d[k];
         comb_out_q <= comb_out_d;
      end
   end

   // Zero stuffing: the comb result enters the integrators for exactly one clk per slot
   assign inj = inj_en_q ? comb_out_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STGS; k++) int_q[k] <= '0;
         y_q <= '0;
      end else begin
         int_q[0] <= int_q[0] + inj;
         for (int unsigned k = 1; k < STGS; k++) int_q[k] <= int_q[k] + int_q[k-1];
         y_q <= int_q[STGS-1][SHIFT+WDTH-1:SHIFT];
      end
   end

`ifdef SIGMA_DELTA_DAC_SECOND_ORDER_EN
   localparam int EW = WDTH + 4;
   localparam logic signed [EW+1:0] FB_MAG = (EW + 2)'(2 ** (WDTH - 1));

   function automatic logic signed [EW-1:0] sat(input logic signed [EW+1:0] v);
      if (v[EW+1:EW-1] == 3'b000 || v[EW+1:EW-1] == 3'b111) return v[EW-1:0];
      return v[EW+1] ? {1'b1, {(EW - 1){1'b0}}} : {1'b0, {(EW - 1){1'b1}}};
   endfunction

   logic signed [EW-1:0] i1_q, i2_q, i1_d, i2_d;
   logic signed [EW+1:0] fb;

   always_comb begin
      fb    = pdm_q ? FB_MAG : -FB_MAG;
      i1_d  = sat({{2{i1_q[EW-1]}}, i1_q} + {{(EW + 2 - WDTH){y_q[WDTH-1]}}, y_q} - fb);
      i2_d  = sat({{2{i2_q[EW-1]}}, i2_q} + {{2{i1_q[EW-1]}}, i1_q} - fb);
      pdm_d = ~i2_d[EW-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i1_q  <= '0;
         i2_q  <= '0;
         pdm_q <= 1'b0;
      end else begin
         i1_q  <= i1_d;
         i2_q  <= i2_d;
         pdm_q <= pdm_d;
      end
   end
`else
   // The accumulator carry bit is held in pdm_q; only the low WDTH bits feed back
   logic [WDTH-1:0] acc_q;
   logic [WDTH-1:0] mod_u;
   logic [WDTH:0]   acc_d;

   always_comb begin
      mod_u = {~y_q[WDTH-1], y_q[WDTH-2:0]};
      acc_d = {1'b0, acc_q} + {1'b0, mod_u};
      pdm_d = acc_d[WDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         pdm_q <= 1'b0;
      end else begin
         acc_q <= acc_d[WDTH-1:0];
         pdm_q <= pdm_d;
      end
   end
`endif

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Scoreboard bench for sigma_delta_dac: expected transfers, underrun pulses and pdm windows are queued
// by the stimulus and checked by a negedge monitor.
module tb_sigma_delta_dac;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [15:0] din = '0;
   logic               din_valid = 1'b0;
   logic               din_ready;
   logic               pdm_out;
   logic               underrun;

   sigma_delta_dac #(.BOSR(256), .STGS(2), .WDTH(16)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .pdm_out(pdm_out), .underrun(underrun)
   );

   always #5 clk = ~clk;

`ifdef SIGMA_DELTA_DAC_SECOND_ORDER_EN
   localparam bit SO = 1'b1;
`else
   localparam bit SO = 1'b0;
`endif

   typedef struct {
      string name;
      int    start, len;
      int    ones_lo, ones_hi, tog_lo, tog_hi, rdy_lo, rdy_hi;
   } win_t;

   win_t win_q[$];
   int   xfer_q[$];
   int   urun_q[$];
   int   cyc;
   int   n_chk = 0;
   int   n_err = 0;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic void check(string name, longint act, longint lo, longint hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
      end
   endfunction

   // Monitor: compares every DUT event against the head of the matching queue
   int ones, togs, rdys;
   bit last_pdm;
   always @(negedge clk) begin
      if (!rst) begin
         if (din_valid && din_ready) begin
            if (xfer_q.size() == 0) check("xfer_extra", cyc, -1, -1);
            else begin
               int e;
               e = xfer_q.pop_front();
               check("xfer_cycle", cyc, e, e);
            end
         end
         if (underrun) begin
            if (urun_q.size() == 0) check("underrun_extra", cyc, -1, -1);
            else begin
               int e;
               e = urun_q.pop_front();
               check("underrun_cycle", cyc, e, e);
            end
         end
         if (win_q.size() != 0) begin
            win_t w;
            w = win_q[0];
            if (cyc >= w.start && cyc < w.start + w.len) begin
               if (cyc == w.start) begin
                  ones = 0; togs = 0; rdys = 0;
               end else if (pdm_out != last_pdm) togs++;
               ones += int'(pdm_out);
               rdys += int'(din_ready);
               if (cyc == w.start + w.len - 1) begin
                  if (w.ones_hi >= 0) check({w.name, "_ones"}, ones, w.ones_lo, w.ones_hi);
                  if (w.tog_hi >= 0)  check({w.name, "_toggles"}, togs, w.tog_lo, w.tog_hi);
                  if (w.rdy_hi >= 0)  check({w.name, "_ready"}, rdys, w.rdy_lo, w.rdy_hi);
                  void'(win_q.pop_front());
               end
            end
         end
         last_pdm = pdm_out;
      end
   end

   task automatic add_win(string nm, int st, int ln, int olo, int ohi, int tlo, int thi,
                          int rlo, int rhi);
      win_t w;
      w.name = nm; w.start = st; w.len = ln;
      w.ones_lo = olo; w.ones_hi = ohi; w.tog_lo = tlo; w.tog_hi = thi;
      w.rdy_lo = rlo; w.rdy_hi = rhi;
      win_q.push_back(w);
   endtask

   task automatic wait_cyc(int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic end_phase(string nm);
      check({nm, "_xfer_left"}, xfer_q.size(), 0, 0);
      check({nm, "_underrun_left"}, urun_q.size(), 0, 0);
      check({nm, "_window_left"}, win_q.size(), 0, 0);
      xfer_q.delete();
      urun_q.delete();
      win_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle: y=0 gives 0,1,0,1 from cyc 1 on (ones on even cycles)
      add_win("idle", 4, 2040, SO ? 1000 : 1020, SO ? 1040 : 1020,
              2039, SO ? -1 : 2039, 2040, 2040);
      wait_cyc(2048);
      end_phase("idle");

      // Most negative input, always valid: transfers on cnt==0 slots only
      do_reset();
      for (int k = 0; k <= 6; k++) xfer_q.push_back(k * 256);
      add_win("negfs", 600, 1024, 0, SO ? -1 : 0, 0, SO ? -1 : 0, 4, 4);
      din = 16'sh8000;
      din_valid = 1'b1;
      wait_cyc(1624);
      din_valid = 1'b0;
      wait_cyc(1630);
      end_phase("negfs");

      // Half-scale positive: ones density 3/4, period-4 pattern
      do_reset();
      for (int k = 0; k <= 19; k++) xfer_q.push_back(k * 256);
      add_win("half", 1024, 4096, SO ? 3068 : 3071, SO ? 3076 : 3073,
              2047, SO ? -1 : 2048, 16, 16);
      din = 16'sh4000;
      din_valid = 1'b1;
      wait_cyc(5119);
      din_valid = 1'b0;
      wait_cyc(5130);
      end_phase("half");

      // Eight zero samples then starve: underrun one clk after every later tick
      do_reset();
      for (int k = 0; k <= 7; k++) xfer_q.push_back(k * 256);
      for (int k = 9; k <= 12; k++) urun_q.push_back(k * 256);
      add_win("starve", 2100, 1024, 508, 516, 1023, SO ? -1 : 1023, 1024, 1024);
      din = 16'sh0000;
      din_valid = 1'b1;
      wait_cyc(1793);
      din_valid = 1'b0;
      wait_cyc(3200);
      end_phase("starve");

      // Mid-stream reset: state cleared, counter phase restarts, started cleared
      do_reset();
      for (int k = 0; k <= 3; k++) xfer_q.push_back(k * 256);
      din = 16'sh4000;
      din_valid = 1'b1;
      wait_cyc(1000);
      end_phase("prereset");
      do_reset();
      add_win("rst_now", 0, 1, 0, 0, 0, -1, 1, 1);
      add_win("rst_idle", 1, 99, 0, -1, 0, -1, 99, 99);
      xfer_q.push_back(100);
      xfer_q.push_back(256);
      xfer_q.push_back(512);
      urun_q.push_back(1024);
      wait_cyc(100);
      din_valid = 1'b1;
      wait_cyc(513);
      din_valid = 1'b0;
      wait_cyc(1030);
      end_phase("postreset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
